// File: rtl/signal_sequencer.sv
// signal_sequencer
// Self-timed two-road intersection controller with pedestrian service.
// A registered Moore FSM and an interval down-counter drive the north
// (main) and east (side) light heads plus a walk lamp.
//
// Ports:
//   clk    rising-edge clock
//   R      synchronous active-high reset
//   C      east car sensor (level)
//   P      pedestrian request (pulse or level), latched into pend
//   NR/NG/NY  north red/green/yellow
//   ER/EG/EY  east red/green/yellow
//   WALK   walk lamp
//   P_ACK  one-cycle pulse in the first cycle of the pedestrian phase
//   IC     interval complete (counter at zero)
module signal_sequencer #(
  parameter int LONG_T   = 8,
  parameter int SHORT_T  = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 4,
  parameter int MAX_EAST = 6,
  parameter int CW       = 4
) (
  input  logic clk,
  input  logic R,
  input  logic C,
  input  logic P,
  output logic NR,
  output logic NG,
  output logic NY,
  output logic ER,
  output logic EG,
  output logic EY,
  output logic WALK,
  output logic P_ACK,
  output logic IC
);

  typedef enum logic [2:0] {
    N_GRN = 3'd0,
    N_YEL = 3'd1,
    AR1   = 3'd2,
    E_GRN = 3'd3,
    E_YEL = 3'd4,
    AR2   = 3'd5,
    PED   = 3'd6
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          pend;
  logic          p_ack_q;
  logic          cnt_zero;
  logic          enter_ped;

  // Reload value for a state: its duration minus one, so a state exited on
  // expiry is occupied exactly its duration in cycles.
  function automatic logic [CW-1:0] reload(input state_t s);
    case (s)
      N_GRN:   reload = CW'(LONG_T - 1);
      N_YEL:   reload = CW'(SHORT_T - 1);
      AR1:     reload = CW'(ALLRED_T - 1);
      E_GRN:   reload = CW'(MAX_EAST - 1);
      E_YEL:   reload = CW'(SHORT_T - 1);
      AR2:     reload = CW'(ALLRED_T - 1);
      PED:     reload = CW'(WALK_T - 1);
      default: reload = CW'(LONG_T - 1);
    endcase
  endfunction

  assign cnt_zero  = (cnt == '0);
  assign enter_ped = (next_state == PED) && (state != PED);

  always_comb begin
    next_state = state;
    case (state)
      // North green dwells indefinitely until someone is waiting.
      N_GRN: if (cnt_zero && (C || pend)) next_state = N_YEL;
      N_YEL: if (cnt_zero) next_state = AR1;
      // Pedestrians are served before east when both are waiting, so a
      // single yellow/all-red clearance is shared.
      AR1: begin
        if (cnt_zero) begin
          if (pend)   next_state = PED;
          else if (C) next_state = E_GRN;
          else        next_state = N_GRN;
        end
      end
      PED: begin
        if (cnt_zero) next_state = C ? E_GRN : N_GRN;
      end
      // East green ends early as soon as the car sensor drops.
      E_GRN: if (!C || cnt_zero) next_state = E_YEL;
      E_YEL: if (cnt_zero) next_state = AR2;
      AR2: begin
        if (cnt_zero) next_state = pend ? PED : N_GRN;
      end
      default: next_state = N_GRN;
    endcase
  end

  // A state change always reloads the counter, so the zero-hold in the
  // decrement path only matters while N_GRN dwells.
  // pend is cleared on the edge entering PED, and a P seen on that same edge
  // is absorbed; a held P therefore re-latches one edge later, which yields
  // one pedestrian phase per full cycle.
  always_ff @(posedge clk) begin
    if (R) begin
      state   <= N_GRN;
      cnt     <= CW'(LONG_T - 1);
      pend    <= 1'b0;
      p_ack_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        cnt <= reload(next_state);
      end else if (!cnt_zero) begin
        cnt <= cnt - CNT_ONE;
      end
      if (enter_ped) begin
        pend <= 1'b0;
      end else if (P) begin
        pend <= 1'b1;
      end
      p_ack_q <= enter_ped;
    end
  end

  // Lamps decode only from the state register; unused encodings show
  // all-red until the next edge returns the FSM to N_GRN.
  always_comb begin
    NR   = 1'b0;
    NG   = 1'b0;
    NY   = 1'b0;
    ER   = 1'b0;
    EG   = 1'b0;
    EY   = 1'b0;
    WALK = 1'b0;
    case (state)
      N_GRN: begin NG = 1'b1; ER = 1'b1; end
      N_YEL: begin NY = 1'b1; ER = 1'b1; end
      AR1:   begin NR = 1'b1; ER = 1'b1; end
      E_GRN: begin NR = 1'b1; EG = 1'b1; end
      E_YEL: begin NR = 1'b1; EY = 1'b1; end
      AR2:   begin NR = 1'b1; ER = 1'b1; end
      PED:   begin NR = 1'b1; ER = 1'b1; WALK = 1'b1; end
      default: begin NR = 1'b1; ER = 1'b1; end
    endcase
  end

  assign P_ACK = p_ack_q;
  assign IC    = cnt_zero;

endmodule
